// File: rtl/regfile_wb_stage.sv
// Write-back stage and 32-entry register file: the write-back value sits in a
// one-entry pending register for one cycle, then commits to the array.
module regfile_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic              wb_sel,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wb_pending,
    output logic [ADDR_W-1:0] wb_pend_addr
);

    localparam int NREGS = 1 << ADDR_W;

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0] pend_data_q,  pend_data_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Capture: writes to register 0 are dropped here so they never become pending.
    always_comb begin
        pend_valid_d = 1'b0;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (wb_en && (wb_addr != '0)) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = wb_addr;
            pend_data_d  = wb_sel ? mem_out : alu_out;
        end
    end

    // Commit: the entry captured on the previous edge lands in the array.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (pend_valid_q) begin
            regs_d[pend_addr_q] = pend_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read priority: address 0, then the pending entry, then the array.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (pend_valid_q && (rd_addr1 == pend_addr_q)) begin
            rd_data1 = pend_data_q;
        end
        if (rd_addr1 == '0) begin
            rd_data1 = '0;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (pend_valid_q && (rd_addr2 == pend_addr_q)) begin
            rd_data2 = pend_data_q;
        end
        if (rd_addr2 == '0) begin
            rd_data2 = '0;
        end
    end

    assign wb_pending   = pend_valid_q;
    assign wb_pend_addr = pend_addr_q;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Bench for regfile_wb_stage: directed scenarios plus a randomized run checked
// against an architectural model (last written value per register).
module tb_regfile_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic        wb_sel = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] mem_out = '0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wb_pending;
    logic [4:0]  wb_pend_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Architectural model: value each register shows once its write has been captured.
    logic [31:0] vis [32];
    logic        pend_m = 1'b0;
    logic [4:0]  pend_addr_m = '0;

    regfile_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en        (wb_en),
        .wb_sel       (wb_sel),
        .wb_addr      (wb_addr),
        .alu_out      (alu_out),
        .mem_out      (mem_out),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .wb_pending   (wb_pending),
        .wb_pend_addr (wb_pend_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : vis[a];
    endfunction

    task automatic drive_wb(input logic en, input logic sel, input logic [4:0] addr,
                            input logic [31:0] alu, input logic [31:0] mem);
        wb_en   = en;
        wb_sel  = sel;
        wb_addr = addr;
        alu_out = alu;
        mem_out = mem;
    endtask

    // One clock edge; the model takes the inputs as they stand at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) vis[i] = 32'h0;
            pend_m      = 1'b0;
            pend_addr_m = 5'd0;
        end else if (wb_en && wb_addr != 5'd0) begin
            vis[wb_addr] = wb_sel ? mem_out : alu_out;
            pend_m       = 1'b1;
            pend_addr_m  = wb_addr;
        end else begin
            pend_m = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) vis[i] = 32'hx;
        rst = 1'b1;
        drive_wb(1'b1, 1'b0, 5'd3, 32'h5555_5555, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        n_cmp++;
        if (wb_pending !== 1'b0 || wb_pend_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_pending: got pend=%b addr=%0d, want pend=0 addr=0", wb_pending, wb_pend_addr);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = a[4:0];
            rd_addr2 = 5'(31 - a);
            #1;
            n_cmp++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: got %h/%h, want 0/0", a, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_basic_write();
        drive_wb(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        rd_addr1 = 5'd5;
        #1;
        n_cmp++;
        if (rd_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_before_edge: got %h, want 00000000", rd_data1);
        end
        tick();
        n_cmp++;
        if (rd_data1 !== 32'h1234_5678 || wb_pending !== 1'b1 || wb_pend_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL basic_bypass: got %h pend=%b addr=%0d, want 12345678 pend=1 addr=5",
                     rd_data1, wb_pending, wb_pend_addr);
        end
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if (rd_data1 !== 32'h1234_5678 || wb_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_array: got %h pend=%b, want 12345678 pend=0", rd_data1, wb_pending);
        end
    endtask

    task automatic test_zero_write();
        drive_wb(1'b1, 1'b1, 5'd0, 32'h0, 32'hFFFF_FFFF);
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (wb_pending !== 1'b0 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
                n_fail++;
                $display("FAIL zero_write k=%0d: got pend=%b %h/%h, want pend=0 0/0",
                         k, wb_pending, rd_data1, rd_data2);
            end
        end
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        rd_addr2 = 5'd7;
        drive_wb(1'b1, 1'b0, 5'd7, 32'h0000_0011, 32'h0);
        tick();
        n_cmp++;
        if (rd_data2 !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL b2b_first: got %h, want 00000011", rd_data2);
        end
        drive_wb(1'b1, 1'b0, 5'd7, 32'h0000_0022, 32'h0);
        tick();
        n_cmp++;
        if (rd_data2 !== 32'h0000_0022 || wb_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got %h pend=%b, want 00000022 pend=1", rd_data2, wb_pending);
        end
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (rd_data2 !== 32'h0000_0022) begin
                n_fail++;
                $display("FAIL b2b_array k=%0d: got %h, want 00000022", k, rd_data2);
            end
        end
    endtask

    task automatic test_reset_discard();
        rd_addr1 = 5'd9;
        drive_wb(1'b1, 1'b0, 5'd9, 32'hAAAA_0000, 32'h0);
        tick();
        n_cmp++;
        if (rd_data1 !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL discard_bypass: got %h, want aaaa0000", rd_data1);
        end
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (rd_data1 !== 32'h0 || wb_pending !== 1'b0 || wb_pend_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL discard_after_rst: got %h pend=%b addr=%0d, want 0 pend=0 addr=0",
                     rd_data1, wb_pending, wb_pend_addr);
        end
    endtask

    task automatic test_alternate();
        rd_addr1 = 5'd1;
        rd_addr2 = 5'd2;
        drive_wb(1'b1, 1'b0, 5'd1, 32'h1, 32'h0);
        tick();
        drive_wb(1'b1, 1'b1, 5'd2, 32'h0, 32'h2);
        tick();
        n_cmp++;
        if (rd_data1 !== 32'h1 || rd_data2 !== 32'h2 || wb_pend_addr !== 5'd2) begin
            n_fail++;
            $display("FAIL alternate: got %h/%h addr=%0d, want 1/2 addr=2", rd_data1, rd_data2, wb_pend_addr);
        end
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            drive_wb(1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom, $urandom);
            rd_addr1 = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 5));
            rd_addr2 = ($urandom_range(0, 1) == 0) ? pend_addr_m : 5'($urandom_range(0, 31));
            #1;
            n_cmp++;
            if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2)) begin
                n_fail++;
                $display("FAIL rand_pre c=%0d: got %h/%h, want %h/%h", c, rd_data1, rd_data2,
                         exp_rd(rd_addr1), exp_rd(rd_addr2));
            end
            tick();
            n_cmp++;
            if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2) ||
                wb_pending !== pend_m || (pend_m && wb_pend_addr !== pend_addr_m)) begin
                n_fail++;
                $display("FAIL rand_post c=%0d: got %h/%h pend=%b addr=%0d, want %h/%h pend=%b addr=%0d",
                         c, rd_data1, rd_data2, wb_pending, wb_pend_addr,
                         exp_rd(rd_addr1), exp_rd(rd_addr2), pend_m, pend_addr_m);
            end
        end
        rst = 1'b0;
        drive_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        // Sweep every register once the pipeline has drained to check array contents.
        for (int r = 0; r < 32; r++) begin
            rd_addr1 = r[4:0];
            rd_addr2 = 5'(31 - r);
            #1;
            n_cmp++;
            if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2)) begin
                n_fail++;
                $display("FAIL rand_sweep r=%0d: got %h/%h, want %h/%h", r, rd_data1, rd_data2,
                         exp_rd(rd_addr1), exp_rd(rd_addr2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_write();
        test_back_to_back();
        test_reset_discard();
        test_alternate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_stage.md
Name: regfile_wb_stage

Overview:
- Write-back stage plus register file for the MIPS datapath.
- Selects the ALU result or the memory read data for write-back and captures it in a one-entry pending write register.
- Commits that entry to a 32x32 register array on the following cycle.
- Serves two combinational read ports with bypass from the pending entry, so decode sees the newest value without stalling.

Parameters:
- DATA_W, 32, width of each register and data path
- ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- wb_en  input  1  write-back request this cycle
- wb_sel  input  1  0 = write alu_out, 1 = write mem_out
- wb_addr  input  ADDR_W  destination register
- alu_out  input  DATA_W  ALU result
- mem_out  input  DATA_W  data-memory read data
- rd_addr1  input  ADDR_W  read port 1 address
- rd_addr2  input  ADDR_W  read port 2 address
- rd_data1  output  DATA_W  read port 1 data (combinational)
- rd_data2  output  DATA_W  read port 2 data (combinational)
- wb_pending  output  1  pending write entry valid
- wb_pend_addr  output  ADDR_W  destination of pending entry (hazard visibility)

Behaviour:
- One clock domain; reset is synchronous and active-high (rst sampled on rising clk edge).
- Reset:
  - All array registers = 0.
  - pend_valid = 0, pend_addr = 0, pend_data = 0.
  - Therefore wb_pending = 0, wb_pend_addr = 0, and rd_data1/rd_data2 = 0 for every address on the cycle after reset.
- Reset mid-operation: the pending entry is discarded (not committed); reset has priority over all other inputs.
- Capture (edge N, rst = 0):
  - If wb_en = 1 and wb_addr != 0: pend_valid <= 1, pend_addr <= wb_addr, pend_data <= (wb_sel ? mem_out : alu_out).
  - Otherwise pend_valid <= 0.
- Commit (same edge N): if pend_valid = 1 before the edge, array[pend_addr] <= pend_data.
  - Capture and commit happen together, giving a 2-edge write latency into the array.
- Register 0:
  - Hardwired zero; writes to 0 are dropped at capture (never become pending).
  - A read of address 0 always returns 0.
- Read path, per port, in priority order:
  - (a) addr = 0 -> 0
  - (b) pend_valid = 1 and addr = pend_addr -> pend_data
  - (c) otherwise -> array[addr]
- Read timing: a write presented at edge N is readable (via bypass) immediately after edge N; a same-cycle wb_en/read to the same address returns the old value.
- Back-to-back writes, same address:
  - Edge N captures A; edge N+1 commits A and captures B.
  - Reads after N+1 return B (bypass beats array).
- Back-to-back writes, different addresses: both readable after the respective capture edges; no data lost; no stall ever required.
- wb_en = 0 cycles: the pending entry commits and pend_valid drops; array contents are unchanged otherwise.
- Widths: no arithmetic; all data passes unmodified at DATA_W bits.
- Outputs: wb_pending = pend_valid and wb_pend_addr = pend_addr, both registered.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0x00000000; wb_pending = 0.
- wb_en = 1, wb_sel = 0, wb_addr = 5, alu_out = 0x12345678, mem_out = 0xDEADBEEF; rd_addr1 = 5:
  - Before edge -> 0.
  - After edge 1 -> 0x12345678 (bypass, wb_pending = 1).
  - After edge 2 with wb_en = 0 -> still 0x12345678 (array, wb_pending = 0).
- wb_sel = 1, wb_addr = 0, mem_out = 0xFFFFFFFF -> wb_pending stays 0; rd_data on address 0 = 0 forever.
- Back-to-back writes to address 7: 0x00000011, then 0x00000022 on consecutive edges -> rd_data2 (addr 7) = 0x11 after edge 1, 0x22 after edge 2 and thereafter; address 7 in the array ends at 0x22.
- Write 0xAAAA0000 to address 9 and assert rst on the next edge -> address 9 reads 0 afterwards, wb_pending = 0 (pending entry discarded).
- Alternating writes to addresses 1 and 2 (0x1, then 0x2) with rd_addr1 = 1 and rd_addr2 = 2 -> after the second edge rd_data1 = 0x1 (array) and rd_data2 = 0x2 (bypass) simultaneously.
